// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches a 16-bit word at pc, resolves one level of
// indirection for memory-reference opcodes, and presents the result via a valid/ready handshake.
module instr_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        pc_load,
  input  logic [11:0] pc_in,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        ir_i,
  output logic [2:0]  ir_opcode,
  output logic [11:0] ir_addr,
  output logic [11:0] ea,
  output logic [11:0] pc
);

  // state | meaning
  // IDLE  | stopped; accepts pc_load, waits for run
  // FETCH | instruction read issued at pc
  // FCAP  | instruction word captured into IR, pc advanced
  // INDIR | indirect pointer read issued at ir_addr
  // ICAP  | pointer captured into ea
  // HOLD  | instruction presented; waits for ir_ready
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    FCAP  = 3'd2,
    INDIR = 3'd3,
    ICAP  = 3'd4,
    HOLD  = 3'd5
  } state_t;

  state_t state;

  logic        rdata_indirect;
  logic [11:0] pc_next_fetch;

  // Register/IO format (opcode 111) reuses bit 15 as a sub-opcode, never as indirection.
  assign rdata_indirect = mem_rdata[15] && (mem_rdata[14:12] != 3'b111);
  assign pc_next_fetch  = pc_load ? pc_in : pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= 12'h000;
      mem_addr  <= 12'h000;
      mem_rd    <= 1'b0;
      ir_valid  <= 1'b0;
      ir_i      <= 1'b0;
      ir_opcode <= 3'b000;
      ir_addr   <= 12'h000;
      ea        <= 12'h000;
    end else begin
      unique case (state)
        IDLE: begin
          if (pc_load) pc <= pc_in;
          if (run) begin
            state    <= FETCH;
            mem_rd   <= 1'b1;
            mem_addr <= pc_next_fetch;
          end
        end
        FETCH: begin
          mem_rd <= 1'b0;
          state  <= FCAP;
        end
        FCAP: begin
          ir_i      <= mem_rdata[15];
          ir_opcode <= mem_rdata[14:12];
          ir_addr   <= mem_rdata[11:0];
          pc        <= pc + 12'd1;
          if (rdata_indirect) begin
            state    <= INDIR;
            mem_rd   <= 1'b1;
            mem_addr <= mem_rdata[11:0];
          end else begin
            ea       <= mem_rdata[11:0];
            ir_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        INDIR: begin
          mem_rd <= 1'b0;
          state  <= ICAP;
        end
        ICAP: begin
          ea       <= mem_rdata[11:0];
          ir_valid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            // A branch target loaded here overrides the pc+1 taken in FCAP.
            if (pc_load) pc <= pc_in;
            if (run) begin
              state    <= FETCH;
              mem_rd   <= 1'b1;
              mem_addr <= pc_next_fetch;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          mem_rd   <= 1'b0;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table of single-instruction fetches
// followed by hand-written backpressure, branch, run-stop and reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        pc_load;
  logic [11:0] pc_in;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic        ir_i;
  logic [2:0]  ir_opcode;
  logic [11:0] ir_addr;
  logic [11:0] ea;
  logic [11:0] pc;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [4096];
  int          rd_cnt = 0;
  logic [11:0] rd_log [16];

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .run(run), .pc_load(pc_load), .pc_in(pc_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_i(ir_i), .ir_opcode(ir_opcode),
    .ir_addr(ir_addr), .ea(ea), .pc(pc)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for a read strobed on one edge appears the next cycle.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_log[rd_cnt % 16] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  typedef struct {
    logic [11:0] start;
    logic [15:0] word;
    logic [15:0] ind_word;
    logic        exp_i;
    logic [2:0]  exp_op;
    logic [11:0] exp_ea;
    logic [11:0] exp_pc;
    int          exp_lat;
    int          exp_reads;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ir_valid && n < 20);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, {20'd0, pc}, 32'h0);
    chk({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'h0);
    chk({tag, "_ir_addr"}, {20'd0, ir_addr}, 32'h0);
    chk({tag, "_ea"}, {20'd0, ea}, 32'h0);
    chk({tag, "_opcode"}, {29'd0, ir_opcode}, 32'h0);
    chk({tag, "_ir_i"}, {31'd0, ir_i}, 32'h0);
    chk({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'h0);
    chk({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'h0);
  endtask

  initial begin
    int n;
    int rd0;
    for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;

    //           start   word      ind_word  i     op    ea      pc      lat reads
    vecs[0] = '{12'h000, 16'h2123, 16'h0000, 1'b0, 3'd2, 12'h123, 12'h001, 2, 1};
    vecs[1] = '{12'h005, 16'h9040, 16'h0ABC, 1'b1, 3'd1, 12'hABC, 12'h006, 4, 2};
    vecs[2] = '{12'h000, 16'hF800, 16'h0000, 1'b1, 3'd7, 12'h800, 12'h001, 2, 1};
    vecs[3] = '{12'hFFF, 16'h7ABC, 16'h0000, 1'b0, 3'd7, 12'hABC, 12'h000, 2, 1};
    vecs[4] = '{12'h100, 16'hC200, 16'hF345, 1'b1, 3'd4, 12'h345, 12'h101, 4, 2};
    vecs[5] = '{12'h7FF, 16'h0FFF, 16'h0000, 1'b0, 3'd0, 12'hFFF, 12'h800, 2, 1};
    vecs[6] = '{12'h010, 16'hE020, 16'h1234, 1'b1, 3'd6, 12'h234, 12'h011, 4, 2};

    reset = 1'b0; run = 1'b0; pc_load = 1'b0; pc_in = 12'h000; ir_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_rd", {31'd0, mem_rd}, 32'h0);

    for (int v = 0; v < 7; v++) begin
      mem[vecs[v].start] = vecs[v].word;
      if (vecs[v].exp_reads == 2) mem[vecs[v].word[11:0]] = vecs[v].ind_word;
      rd0 = rd_cnt;
      pc_load = 1'b1; pc_in = vecs[v].start; run = 1'b1; ir_ready = 1'b0;
      @(negedge clk);
      pc_load = 1'b0;
      chk($sformatf("v%0d_fetch_rd", v), {31'd0, mem_rd}, 32'h1);
      chk($sformatf("v%0d_fetch_addr", v), {20'd0, mem_addr}, {20'd0, vecs[v].start});
      wait_valid(n);
      chk($sformatf("v%0d_latency", v), n, vecs[v].exp_lat);
      chk($sformatf("v%0d_reads", v), rd_cnt - rd0, vecs[v].exp_reads);
      if (vecs[v].exp_reads == 2)
        chk($sformatf("v%0d_ind_addr", v), {20'd0, rd_log[(rd0 + 1) % 16]},
            {20'd0, vecs[v].word[11:0]});
      chk($sformatf("v%0d_ir_i", v), {31'd0, ir_i}, {31'd0, vecs[v].exp_i});
      chk($sformatf("v%0d_opcode", v), {29'd0, ir_opcode}, {29'd0, vecs[v].exp_op});
      chk($sformatf("v%0d_ir_addr", v), {20'd0, ir_addr}, {20'd0, vecs[v].word[11:0]});
      chk($sformatf("v%0d_ea", v), {20'd0, ea}, {20'd0, vecs[v].exp_ea});
      chk($sformatf("v%0d_pc", v), {20'd0, pc}, {20'd0, vecs[v].exp_pc});
      run = 1'b0; ir_ready = 1'b1;
      @(negedge clk);
      ir_ready = 1'b0;
      chk($sformatf("v%0d_done_valid", v), {31'd0, ir_valid}, 32'h0);
    end

    // Backpressure, back-to-back handshake and branch priority.
    mem[12'h020] = 16'h3456; mem[12'h021] = 16'h2111; mem[12'h300] = 16'h5222;
    pc_load = 1'b1; pc_in = 12'h020; run = 1'b1; ir_ready = 1'b0;
    @(negedge clk);
    pc_load = 1'b0;
    wait_valid(n);
    chk("bp_latency", n, 2);
    rd0 = rd_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), {31'd0, ir_valid}, 32'h1);
      chk($sformatf("bp%0d_fields", c), {17'd0, ir_opcode, ea}, {17'd0, 3'd3, 12'h456});
      chk($sformatf("bp%0d_no_rd", c), rd_cnt - rd0, 0);
    end
    ir_ready = 1'b1;
    @(negedge clk);
    chk("hs_fetch_rd", {31'd0, mem_rd}, 32'h1);
    chk("hs_fetch_addr", {20'd0, mem_addr}, 32'h021);
    chk("hs_valid_low", {31'd0, ir_valid}, 32'h0);
    wait_valid(n);
    chk("b2b_latency", n, 2);
    chk("b2b_ea", {20'd0, ea}, 32'h111);
    pc_load = 1'b1; pc_in = 12'h300;
    @(negedge clk);
    chk("br_fetch_addr", {20'd0, mem_addr}, 32'h300);
    chk("br_fetch_rd", {31'd0, mem_rd}, 32'h1);
    pc_in = 12'h555;
    wait_valid(n);
    chk("br_latency", n, 2);
    chk("br_ea", {20'd0, ea}, 32'h222);
    chk("br_fcap_load_ignored", {20'd0, pc}, 32'h301);
    pc_load = 1'b0; run = 1'b0;
    @(negedge clk);
    ir_ready = 1'b0;
    chk("br_idle_valid", {31'd0, ir_valid}, 32'h0);
    chk("br_idle_pc", {20'd0, pc}, 32'h301);

    // Dropping run mid-instruction still completes it, then stops.
    mem[12'h050] = 16'h8060; mem[12'h060] = 16'h0777;
    pc_load = 1'b1; pc_in = 12'h050; run = 1'b1;
    @(negedge clk);
    pc_load = 1'b0; run = 1'b0;
    wait_valid(n);
    chk("stop_latency", n, 4);
    chk("stop_ea", {20'd0, ea}, 32'h777);
    ir_ready = 1'b1;
    rd0 = rd_cnt;
    repeat (4) @(negedge clk);
    ir_ready = 1'b0;
    chk("stop_no_rd", rd_cnt - rd0, 0);
    chk("stop_valid", {31'd0, ir_valid}, 32'h0);

    // Asynchronous reset during INDIR.
    pc_load = 1'b1; pc_in = 12'h005; run = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_indir_rd", {31'd0, mem_rd}, 32'h1);
    chk("rst_in_indir_addr", {20'd0, mem_addr}, 32'h040);
    #2 reset = 1'b0; run = 1'b0;
    #1 chk_reset_outputs("async");
    @(negedge clk);
    reset = 1'b1;
    rd0 = rd_cnt;
    repeat (3) @(negedge clk);
    chk("post_rst_no_rd", rd_cnt - rd0, 0);
    run = 1'b1;
    @(negedge clk);
    chk("restart_rd", {31'd0, mem_rd}, 32'h1);
    chk("restart_addr", {20'd0, mem_addr}, 32'h000);
    wait_valid(n);
    chk("restart_ea", {20'd0, ea}, 32'h800);
    run = 1'b0; ir_ready = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
